// File: rtl/mem_dma.sv
// mem_dma: single-channel memory DMA initiator for a word memory with
// combinational read and clocked write.
//   mode=0 copies len words from src to dst in ascending order (one READ
//   cycle followed by one WRITE cycle per word); mode=1 fills len words at
//   dst with pattern (one WRITE cycle per word). Pointers wrap modulo
//   2^ADDR_W.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, mode           transfer request (sampled only in IDLE), copy/fill
//   src, dst, len         base addresses and word count, latched on start
//   pattern               fill value, latched on start
//   abort                 early termination (READ: no write; WRITE: finish it)
//   busy, done            busy in READ/WRITE, one-cycle done pulse
//   words_done            words written in the current or last transfer
//   mem_we, mem_addr,
//   mem_wdata, mem_rdata  memory port
module mem_dma #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] pattern,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  words_done_q, words_done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic              mode_q, mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      cnt_q        <= '0;
      words_done_q <= '0;
      data_q       <= '0;
      pattern_q    <= '0;
      mode_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      cnt_q        <= cnt_d;
      words_done_q <= words_done_d;
      data_q       <= data_d;
      pattern_q    <= pattern_d;
      mode_q       <= mode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    cnt_d        = cnt_q;
    words_done_d = words_done_q;
    data_d       = data_q;
    pattern_d    = pattern_q;
    mode_d       = mode_q;

    case (state_q)
      S_IDLE: begin
        // start has priority over abort; a zero-length request still
        // produces a done pulse and reports zero words.
        if (start) begin
          words_done_d = '0;
          if (len != '0) begin
            src_ptr_d = src;
            dst_ptr_d = dst;
            cnt_d     = len;
            mode_d    = mode;
            pattern_d = pattern;
            state_d   = mode ? S_WRITE : S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        data_d  = mem_rdata;
        state_d = abort ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        // The write in this cycle always commits, even when aborting.
        src_ptr_d    = src_ptr_q + ADDR_W'(1);
        dst_ptr_d    = dst_ptr_q + ADDR_W'(1);
        words_done_d = words_done_q + LEN_W'(1);
        cnt_d        = cnt_q - LEN_W'(1);
        if (abort || (cnt_q == LEN_W'(1))) begin
          state_d = S_DONE;
        end else if (mode_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs decode the registered state and latched operands only.
  always_comb begin
    busy      = (state_q == S_READ) || (state_q == S_WRITE);
    done      = (state_q == S_DONE);
    mem_we    = (state_q == S_WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == S_READ) begin
      mem_addr = src_ptr_q;
    end else if (state_q == S_WRITE) begin
      mem_addr  = dst_ptr_q;
      mem_wdata = mode_q ? pattern_q : data_q;
    end
  end

  assign words_done = words_done_q;

endmodule
